// File: rtl/mmc1_serial_loader_if.sv
// Request/strobe bundle for the MMC1 serial loader. The block drives the
// mapper-side strobe signals and the request handshake outputs.
interface mmc1_serial_loader_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_reg;
   logic [4:0] req_data;
   logic       req_rst;
   logic       cpu_we;
   logic [1:0] cpu_a;
   logic       cpu_d0;
   logic       cpu_d7;
   logic       busy;
   logic       done;

   modport slave (
      input  req_valid, req_reg, req_data, req_rst,
      output req_ready, cpu_we, cpu_a, cpu_d0, cpu_d7, busy, done
   );

   modport master (
      output req_valid, req_reg, req_data, req_rst,
      input  req_ready, cpu_we, cpu_a, cpu_d0, cpu_d7, busy, done
   );
endinterface

// File: rtl/mmc1_serial_loader.sv
// Serialises a 5-bit MMC1 register load into five LSB-first CPU write strobes,
// optionally preceded by a shift-register reset write, with GAP idle cycles between strobes.
module mmc1_serial_loader #(
   parameter int unsigned GAP         = 2,
   parameter bit          RESET_FIRST = 1'b0
) (
   input logic                  clk,
   input logic                  nres,
   mmc1_serial_loader_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RSTW, BITW, GAPW} state_t;

   typedef struct packed {
      logic [1:0] regi;
      logic [4:0] data;
   } req_t;

   // GAPW is left when the counter reaches zero, so it lasts GAP_LOAD+1 cycles.
   localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

   state_t     state_q;
   req_t       req_q;
   logic [2:0] bit_q;
   logic [2:0] bit_d;
   logic [3:0] gap_q;
   logic       last_q;
   logic       we_q;
   logic [1:0] a_q;
   logic       d0_q;
   logic       d7_q;
   logic       done_q;

   // Bit index saturates at 4; the final data strobe leaves it there.
   always_comb begin
      bit_d = (bit_q == 3'd4) ? bit_q : bit_q + 3'd1;
   end

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         state_q <= IDLE;
         req_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         last_q  <= 1'b0;
         we_q    <= 1'b0;
         a_q     <= '0;
         d0_q    <= 1'b0;
         d7_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         d0_q   <= 1'b0;
         d7_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  req_q  <= '{regi: bus.req_reg, data: bus.req_data};
                  bit_q  <= '0;
                  we_q   <= 1'b1;
                  a_q    <= bus.req_reg;
                  // A lone reset write wins over any data presented with it.
                  if (bus.req_rst || RESET_FIRST) begin
                     state_q <= RSTW;
                     d7_q    <= 1'b1;
                     last_q  <= bus.req_rst;
                     done_q  <= bus.req_rst;
                  end else begin
                     state_q <= BITW;
                     d0_q    <= bus.req_data[0];
                     last_q  <= 1'b0;
                  end
               end
            end
            RSTW: begin
               state_q <= GAPW;
               gap_q   <= GAP_LOAD;
            end
            BITW: begin
               state_q <= GAPW;
               gap_q   <= GAP_LOAD;
               last_q  <= (bit_q == 3'd4);
               bit_q   <= bit_d;
            end
            GAPW: begin
               if (gap_q != 4'd0) begin
                  gap_q <= gap_q - 4'd1;
               end else if (last_q) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= BITW;
                  we_q    <= 1'b1;
                  a_q     <= req_q.regi;
                  d0_q    <= req_q.data[bit_q];
                  done_q  <= (bit_q == 3'd4);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.cpu_we    = we_q;
   assign bus.cpu_a     = a_q;
   assign bus.cpu_d0    = d0_q;
   assign bus.cpu_d7    = d7_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Scoreboard bench for mmc1_serial_loader: three instances (GAP=2; GAP=1 with
// RESET_FIRST; GAP=15) driven with directed and random loads.
module tb_mmc1_serial_loader;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  a;
      logic        d0;
      logic        d7;
      logic        done;
   } ev_t;

   logic            clk = 1'b0;
   logic [2:0]      nres, vld, rr;
   logic [2:0][1:0] rg;
   logic [2:0][4:0] dt;
   logic [2:0]      we, d0, d7, done, ready, busy;
   logic [2:0][1:0] a;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   ev_t  sb[3][$];
   int   rdy_at[3];
   int   last_we[3];
   logic [2:0][1:0] last_a;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int unsigned G  = (k == 2) ? 15 : ((k == 1) ? 1 : 2);
      localparam bit          RF = (k == 1);
      mmc1_serial_loader_if bus ();
      assign bus.req_valid = vld[k];
      assign bus.req_reg   = rg[k];
      assign bus.req_data  = dt[k];
      assign bus.req_rst   = rr[k];
      assign we[k]    = bus.cpu_we;
      assign a[k]     = bus.cpu_a;
      assign d0[k]    = bus.cpu_d0;
      assign d7[k]    = bus.cpu_d7;
      assign done[k]  = bus.done;
      assign ready[k] = bus.req_ready;
      assign busy[k]  = bus.busy;
      mmc1_serial_loader #(.GAP(G), .RESET_FIRST(RF)) dut (
         .clk  (clk),
         .nres (nres[k]),
         .bus  (bus)
      );
   end

   function automatic int gap_of(input int k);
      return (k == 2) ? 15 : ((k == 1) ? 1 : 2);
   endfunction

   function automatic bit rf_of(input int k);
      return (k == 1);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected strobe timeline straight from the latency rules: first strobe at
   // T+1, data strobes (1+g) apart, an optional reset write shifting them by (1+g).
   task automatic model(input int k, input int t, input logic [1:0] r,
                        input logic [4:0] d, input logic rs);
      int g = gap_of(k);
      int s = t + 1;
      if (rs) begin
         sb[k].push_back('{32'(t + 1), r, 1'b0, 1'b1, 1'b1});
         rdy_at[k] = t + 2 + g;
      end else begin
         if (rf_of(k)) begin
            sb[k].push_back('{32'(t + 1), r, 1'b0, 1'b1, 1'b0});
            s += 1 + g;
         end
         for (int i = 0; i < 5; i++)
            sb[k].push_back('{32'(s + i * (1 + g)), r, d[i], 1'b0, (i == 4)});
         rdy_at[k] = s + 5 * (1 + g);
      end
   endtask

   // Present a request at posedge+1; returns acceptance cycle (or -1 on timeout).
   task automatic issue(input int k, input logic [1:0] r, input logic [4:0] d,
                        input logic rs, input bit hold, output int t);
      int n = 0;
      vld[k] = 1'b1; rg[k] = r; dt[k] = d; rr[k] = rs;
      t = -1;
      while (n < 300) begin
         @(negedge clk);
         if (ready[k]) begin
            t = cyc;
            break;
         end
         n++;
      end
      check("accept_timeout", 32'(t >= 0), 32'd1);
      @(posedge clk); #1;
      if (t >= 0) model(k, t, r, d, rs);
      if (!hold) vld[k] = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever a strobe appears.
   always @(negedge clk) begin
      ev_t  e;
      logic er;
      logic due;
      for (int k = 0; k < 3; k++) begin
         er = (cyc >= rdy_at[k]);
         check("req_ready", 32'(ready[k]), 32'(er));
         check("busy", 32'(busy[k]), 32'(!er));
         due = (sb[k].size() > 0) && (int'(sb[k][0].cyc) <= cyc);
         check("strobe_timing", 32'(we[k]), 32'(due));
         if (we[k]) begin
            if (sb[k].size() > 0) begin
               e = sb[k].pop_front();
               check("strobe_cycle", 32'(cyc), e.cyc);
               check("strobe_bits", 32'({a[k], d0[k], d7[k], done[k]}),
                     32'({e.a, e.d0, e.d7, e.done}));
               last_a[k] = e.a;
            end else begin
               last_a[k] = a[k];
            end
            if (last_we[k] >= 0)
               check("strobe_spacing", 32'((cyc - last_we[k]) > gap_of(k)), 32'd1);
            last_we[k] = cyc;
         end else begin
            check("idle_outputs", 32'({a[k], d0[k], d7[k], done[k]}), 32'({last_a[k], 3'b000}));
            if (due) void'(sb[k].pop_front());
         end
      end
   end

   initial begin
      int t, t2, n;
      nres = '0; vld = '0; rr = '0; rg = '0; dt = '0; last_a = '0;
      for (int k = 0; k < 3; k++) begin
         rdy_at[k] = 0;
         last_we[k] = -1;
      end
      #1;
      for (int k = 0; k < 3; k++)
         check("reset_state", 32'({we[k], a[k], d0[k], d7[k], done[k], busy[k], ready[k]}), 32'h01);
      repeat (3) @(posedge clk);
      #1 nres = '1;

      // Data load on the first edge after reset release.
      issue(0, 2'd3, 5'b10110, 1'b0, 1'b0, t);
      // Lone reset write; data presented with it must be ignored.
      issue(0, 2'd0, 5'b11111, 1'b1, 1'b0, t);

      // Valid held and data scrambled while busy.
      issue(0, 2'd1, 5'b01101, 1'b0, 1'b1, t);
      t2 = -1;
      for (n = 0; n < 100; n++) begin
         dt[0] = 5'($urandom);
         rg[0] = 2'($urandom);
         @(negedge clk);
         if (ready[0]) begin
            t2 = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      check("hold_reaccept_cycle", 32'(t2), 32'(t + 16));
      @(posedge clk); #1;
      if (t2 >= 0) model(0, t2, rg[0], dt[0], rr[0]);
      vld[0] = 1'b0;

      // Reset pulse in the gap after the bit 2 strobe.
      issue(0, 2'd2, 5'b11011, 1'b0, 1'b0, t);
      n = 0;
      while (cyc < t + 8 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      nres[0] = 1'b0;
      sb[0].delete();
      rdy_at[0] = 0;
      last_a[0] = '0;
      last_we[0] = -1;
      #1 check("async_abort", 32'({we[0], done[0], ready[0], busy[0]}), 32'b0010);
      repeat (2) @(posedge clk);
      #1 nres[0] = 1'b1;
      issue(0, 2'd0, 5'b00111, 1'b0, 1'b0, t);

      // RESET_FIRST instance, then the widest gap.
      issue(1, 2'd1, 5'b00001, 1'b0, 1'b0, t);
      issue(2, 2'd2, 5'b10011, 1'b0, 1'b0, t);

      // Random loads, including back-to-back and reset-with-data requests.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++) begin
            issue(k, 2'($urandom), 5'($urandom), ($urandom_range(0, 4) == 0), 1'b0, t);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end

      n = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size() != 0 || ready != 3'b111) && n < 300) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("scoreboard_drained", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
